// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, oversampling ratio, byte width and
// the three mid-bit sample positions used for the majority vote.
package uart_pkg;

   localparam int UART_OVERSAMPLE = 16;
   localparam int UART_DATA_W     = 8;

   // Mid-bit samples voted 2-of-3; the decision is taken on the last one
   localparam int UART_SMP_A = 7;
   localparam int UART_SMP_B = 8;
   localparam int UART_SMP_C = 9;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK
   } uart_state_t;

endpackage

// File: rtl/uart_tick_gen.sv
// Oversample tick generator: one-cycle tick every DIV clocks, restartable so
// the first tick after a restart lands exactly DIV clocks later.
module uart_tick_gen #(
   parameter int DIV = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = (cnt == LAST);

   // Free-running modulo-DIV counter, zeroed by restart or on wrap
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (restart || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 16x oversampled 8N1 (8E1 when UART_RX_PARITY_EN is defined)
// with 2-of-3 majority bit decisions and a one-entry valid/ready buffer.
// Optional feature macro: UART_RX_PARITY_EN (adds PARITY state, parity_err).
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = 96_000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rxd,
   output logic [UART_DATA_W-1:0] data,
   output logic                   valid,
   input  logic                   ready,
   output logic                   frame_err,
   output logic                   overrun
`ifdef UART_RX_PARITY_EN
   ,
   output logic                   parity_err
`endif
);

   // Rounded clocks per oversample tick; must be at least 2
   localparam int DIV = (CLK_FREQ + BAUD * 8) / (BAUD * 16);

   localparam logic [3:0] SC_A     = 4'(UART_SMP_A);
   localparam logic [3:0] SC_B     = 4'(UART_SMP_B);
   localparam logic [3:0] SC_C     = 4'(UART_SMP_C);
   localparam logic [3:0] SC_LAST  = 4'(UART_OVERSAMPLE - 1);
   localparam logic [2:0] LAST_BIT = 3'(UART_DATA_W - 1);

   uart_state_t            state_q, state_d;
   logic                   sync1, rxs, rxs_d;
   logic                   tick, restart;
   logic [3:0]             sc;
   logic [2:0]             bit_idx;
   logic [1:0]             smp;
   logic [UART_DATA_W-1:0] shreg;
   logic                   maj, decide, bit_end;
   logic                   commit, ferr;
`ifdef UART_RX_PARITY_EN
   logic                   par_bit, par_bad, perr;

   // Even parity: data bits plus parity bit must have an even count of ones
   assign par_bad = ^{shreg, par_bit};
`endif

   assign maj     = (smp[0] & smp[1]) | (smp[0] & rxs) | (smp[1] & rxs);
   assign decide  = tick && (sc == SC_C);
   assign bit_end = tick && (sc == SC_LAST);

   // Two-flop synchronizer plus previous-value flop for start-edge detection
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= 1'b1;
         rxs   <= 1'b1;
         rxs_d <= 1'b1;
      end else begin
         sync1 <= rxd;
         rxs   <= sync1;
         rxs_d <= rxs;
      end
   end

   uart_tick_gen #(
      .DIV (DIV)
   ) u_tick (
      .clk     (clk),
      .rst     (rst),
      .restart (restart),
      .tick    (tick)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and strobe decode
   always_comb begin
      state_d = state_q;
      restart = 1'b0;
      commit  = 1'b0;
      ferr    = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr    = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (!rxs && rxs_d) begin
               state_d = ST_START;
               restart = 1'b1;
            end
         end
         ST_START: begin
            if (decide && maj) begin
               state_d = ST_IDLE;
            end else if (bit_end) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (bit_end && (bit_idx == LAST_BIT)) begin
`ifdef UART_RX_PARITY_EN
               state_d = ST_PARITY;
`else
               state_d = ST_STOP;
`endif
            end
         end
         ST_PARITY: begin
            if (bit_end) begin
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            // Leave at mid-stop so a slightly fast sender's next start is caught
            if (decide) begin
`ifdef UART_RX_PARITY_EN
               perr   = par_bad;
               commit = maj && !par_bad;
`else
               commit = maj;
`endif
               if (maj) begin
                  state_d = ST_IDLE;
               end else begin
                  ferr    = 1'b1;
                  state_d = ST_BREAK;
               end
            end
         end
         ST_BREAK: begin
            if (rxs) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Sample counter, bit index, majority samples and data shift register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sc      <= '0;
         bit_idx <= '0;
         smp     <= '0;
         shreg   <= '0;
`ifdef UART_RX_PARITY_EN
         par_bit <= 1'b0;
`endif
      end else begin
         if (restart) begin
            sc <= '0;
         end else if (tick) begin
            sc <= sc + 4'd1;
         end
         if (restart) begin
            bit_idx <= '0;
         end else if ((state_q == ST_DATA) && bit_end) begin
            bit_idx <= bit_idx + 3'd1;
         end
         if (tick && (sc == SC_A)) begin
            smp[0] <= rxs;
         end
         if (tick && (sc == SC_B)) begin
            smp[1] <= rxs;
         end
         if ((state_q == ST_DATA) && decide) begin
            shreg <= {maj, shreg[UART_DATA_W-1:1]};
         end
`ifdef UART_RX_PARITY_EN
         if ((state_q == ST_PARITY) && decide) begin
            par_bit <= maj;
         end
`endif
      end
   end

   // One-entry output buffer and registered error pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data      <= '0;
         valid     <= 1'b0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
      end else begin
         overrun   <= 1'b0;
         frame_err <= ferr;
`ifdef UART_RX_PARITY_EN
         parity_err <= perr;
`endif
         if (commit) begin
            if (!valid || ready) begin
               data  <= shreg;
               valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (valid && ready) begin
            valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core at DIV = 10 (160 clocks per bit): vector table,
// randomized frames against a byte-queue model, and corner-case sequences.
module tb_uart_rx_core;

   localparam int CLK_FREQ = 1_600_000;
   localparam int BAUD     = 10_000;
   localparam int BIT_CLKS = 160;
`ifdef UART_RX_PARITY_EN
   localparam int LAT      = (10 * 16 + 10) * 10 + 3;
`else
   localparam int LAT      = (9 * 16 + 10) * 10 + 3;
`endif

   logic       clk   = 1'b0;
   logic       rst   = 1'b0;
   logic       rxd   = 1'b1;
   logic       ready = 1'b1;
   logic [7:0] data;
   logic       valid, frame_err, overrun;
`ifdef UART_RX_PARITY_EN
   logic       parity_err;
`endif

   always #5 clk = ~clk;

   uart_rx_core #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rxd       (rxd),
      .data      (data),
      .valid     (valid),
      .ready     (ready),
      .frame_err (frame_err),
      .overrun   (overrun)
`ifdef UART_RX_PARITY_EN
      ,
      .parity_err(parity_err)
`endif
   );

   int         checks = 0;
   int         failures = 0;
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];
   int         fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, stab_bad = 0;
   logic [7:0] hold = '0;
   bit         holding = 1'b0;

   // Monitor: records transfers and pulse-high cycles just after the negedge
   always begin
      @(negedge clk);
      #1;
      if (rst) begin
         if (valid && ready) got_q.push_back(data);
         if (frame_err) fe_cnt++;
         if (overrun) ov_cnt++;
`ifdef UART_RX_PARITY_EN
         if (parity_err) pe_cnt++;
`endif
         if (valid && !ready) begin
            if (holding && data !== hold) stab_bad++;
            hold    = data;
            holding = 1'b1;
         end else begin
            holding = 1'b0;
         end
      end else begin
         holding = 1'b0;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Compare transferred bytes with the model queue, then empty both
   task automatic check_queue(input string name);
      chk({name, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk({name, "_byte"}, got_q[i], exp_q[i]);
      got_q.delete();
      exp_q.delete();
   endtask

   // Drive one frame starting at a negedge, LSB first
   task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_wrong);
      rxd = 1'b0;
      repeat (BIT_CLKS) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (BIT_CLKS) @(negedge clk);
      end
`ifdef UART_RX_PARITY_EN
      rxd = (^b) ^ par_wrong;
      repeat (BIT_CLKS) @(negedge clk);
`else
      if (par_wrong) rxd = 1'b1;
`endif
      rxd = stop_ok;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   task automatic idle(input int n);
      rxd = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   typedef struct {
      logic [7:0] b;
      bit         stop_ok;
      int         gap;
      bit         exp_valid;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int lat, fe0, ov0, pe0, exp_fe;
      logic [7:0] rb;
      bit rs;

      vecs[0] = '{8'h00, 1'b1, 0,   1'b1};
      vecs[1] = '{8'hFF, 1'b1, 0,   1'b1};
      vecs[2] = '{8'h3C, 1'b1, 37,  1'b1};
      vecs[3] = '{8'h80, 1'b1, 0,   1'b1};
      vecs[4] = '{8'h55, 1'b0, 200, 1'b0};
      vecs[5] = '{8'h01, 1'b1, 0,   1'b1};
      vecs[6] = '{8'h5A, 1'b1, 160, 1'b1};

      // Reset state
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_data", data, 0);
      chk("rst_valid", valid, 0);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_overrun", overrun, 0);
      rst = 1'b1;
      idle(20);

      // 0xA5 with latency from the start edge
      lat = 0;
      fork
         send_frame(8'hA5, 1'b1, 1'b0);
         begin
            while (!valid && lat < 3000) begin
               @(negedge clk);
               lat++;
            end
         end
      join
      chk("a5_latency", (lat >= LAT - 1 && lat <= LAT + 1) ? LAT : lat, LAT);
      idle(50);
      exp_q.push_back(8'hA5);
      check_queue("a5");
      chk("a5_no_ferr", fe_cnt, 0);
      chk("a5_no_ovr", ov_cnt, 0);

      // Vector table, including zero-gap back-to-back and one bad stop bit
      fe0 = fe_cnt;
      exp_fe = 0;
      foreach (vecs[i]) begin
         send_frame(vecs[i].b, vecs[i].stop_ok, 1'b0);
         idle(vecs[i].gap);
         if (vecs[i].exp_valid) exp_q.push_back(vecs[i].b);
         else exp_fe++;
      end
      idle(200);
      check_queue("table");
      chk("table_ferr", fe_cnt - fe0, exp_fe);

      // Randomized frames against the byte-queue model
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      exp_fe = 0;
      for (int i = 0; i < 14; i++) begin
         rb = 8'($urandom);
         rs = ($urandom_range(0, 5) != 0);
         send_frame(rb, rs, 1'b0);
         if (rs) begin
            exp_q.push_back(rb);
            idle($urandom_range(0, 300));
         end else begin
            exp_fe++;
            idle($urandom_range(160, 400));
         end
      end
      idle(200);
      check_queue("rand");
      chk("rand_ferr", fe_cnt - fe0, exp_fe);
      chk("rand_ovr", ov_cnt - ov0, 0);

      // Overrun with ready held low
      ov0 = ov_cnt;
      ready = 1'b0;
      send_frame(8'h11, 1'b1, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0);
      idle(200);
      chk("ovr_valid", valid, 1);
      chk("ovr_data", data, 8'h11);
      chk("ovr_pulses", ov_cnt - ov0, 1);
      chk("ovr_stable", stab_bad, 0);
      chk("ovr_no_xfer", got_q.size(), 0);
      ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("ovr_drained", valid, 0);
      exp_q.push_back(8'h11);
      check_queue("ovr");

      // Short glitch is a false start
      fe0 = fe_cnt;
      rxd = 1'b0;
      repeat (40) @(negedge clk);
      idle(400);
      chk("glitch_no_valid", got_q.size(), 0);
      chk("glitch_no_ferr", fe_cnt - fe0, 0);
      send_frame(8'h3C, 1'b1, 1'b0);
      idle(200);
      exp_q.push_back(8'h3C);
      check_queue("glitch");

      // Bad stop followed by a long break
      fe0 = fe_cnt;
      send_frame(8'h55, 1'b0, 1'b0);
      rxd = 1'b0;
      repeat (2000) @(negedge clk);
      idle(320);
      chk("break_ferr", fe_cnt - fe0, 1);
      chk("break_no_valid", got_q.size(), 0);
      send_frame(8'h66, 1'b1, 1'b0);
      idle(200);
      exp_q.push_back(8'h66);
      check_queue("break");

      // Reset during bit 4 of 0x81
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      fork
         send_frame(8'h81, 1'b1, 1'b0);
         begin
            repeat (5 * BIT_CLKS + 80) @(negedge clk);
            rst = 1'b0;
            repeat (2) @(negedge clk);
            chk("midrst_data", data, 0);
            chk("midrst_valid", valid, 0);
         end
      join
      idle(20);
      rst = 1'b1;
      idle(100);
      chk("midrst_no_valid", got_q.size(), 0);
      chk("midrst_no_ferr", fe_cnt - fe0, 0);
      chk("midrst_no_ovr", ov_cnt - ov0, 0);
      send_frame(8'h7E, 1'b1, 1'b0);
      idle(200);
      exp_q.push_back(8'h7E);
      check_queue("midrst");

`ifdef UART_RX_PARITY_EN
      // Wrong parity bit drops the byte
      pe0 = pe_cnt;
      fe0 = fe_cnt;
      send_frame(8'h7E, 1'b1, 1'b1);
      idle(200);
      chk("par_err", pe_cnt - pe0, 1);
      chk("par_no_valid", got_q.size(), 0);
      chk("par_no_ferr", fe_cnt - fe0, 0);
`else
      pe0 = pe_cnt;
      chk("par_absent", pe_cnt - pe0 + got_q.size(), 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
